// File: rtl/qam_frame_ctrl.sv
// QAM frame sequencer (preamble/payload/gap) with a serial-bit-to-symbol assembler; symbol outputs lag sym_tick by 1 clk.
// No output backpressure: the bit source is throttled through bit_en whenever an assembled symbol is waiting.
module qam_frame_ctrl #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GAP_LEN      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_mod_type,
    input  logic [1:0]  cfg_baud_rate,
    input  logic [7:0]  cfg_frame_len,
    input  logic        bit_tick,
    input  logic        bit_in,
    input  logic        sym_tick,
    output logic        bit_en,
    output logic        mod_type,
    output logic [1:0]  baud_rate,
    output logic [3:0]  sym_data,
    output logic        sym_valid,
    output logic        preamble,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        underrun
);

    localparam int MAXC_PG = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
    localparam int MAXC    = (MAXC_PG > 256) ? MAXC_PG : 256;
    localparam int CW      = $clog2(MAXC);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stop_req_q, stop_req_d;
    logic          mod_q, mod_d;
    logic [1:0]    baud_q, baud_d;
    logic [8:0]    len_q, len_d;
    logic [3:0]    sym_data_q, sym_data_d;
    logic          sym_valid_q, sym_valid_d;
    logic          preamble_q, preamble_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          underrun_q, underrun_d;
    logic [3:0]    shift_q, shift_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [3:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;

    logic          consume;
    logic          clear_asm;
    logic          bit_accept;
    logic [3:0]    shift_in;
    logic [2:0]    bits_needed;
    logic [CW-1:0] len_last;

    assign bit_en      = ((state_q == ST_PREAMBLE) || (state_q == ST_PAYLOAD)) && !hold_full_q;
    assign bit_accept  = bit_tick && bit_en;
    assign shift_in    = {shift_q[2:0], bit_in};
    assign bits_needed = mod_q ? 3'd4 : 3'd2;
    assign len_last    = CW'(len_q - 9'd1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stop_req_d   = stop_req_q;
        mod_d        = mod_q;
        baud_d       = baud_q;
        len_d        = len_q;
        sym_data_d   = 4'h0;
        sym_valid_d  = 1'b0;
        preamble_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        underrun_d   = underrun_q;
        consume      = 1'b0;
        clear_asm    = 1'b0;

        if ((state_q != ST_IDLE) && stop) begin
            stop_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    underrun_d = 1'b0;
                    stop_req_d = stop;
                end
            end
            ST_LOAD: begin
                mod_d   = cfg_mod_type;
                baud_d  = cfg_baud_rate;
                len_d   = (cfg_frame_len == 8'd0) ? 9'd256 : {1'b0, cfg_frame_len};
                cnt_d   = '0;
                state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (sym_tick) begin
                    sym_valid_d = 1'b1;
                    preamble_d  = 1'b1;
                    // even slots carry the high level, odd slots zero
                    if (!cnt_q[0]) begin
                        sym_data_d = mod_q ? 4'hF : 4'h3;
                    end
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (sym_tick) begin
                    sym_valid_d = 1'b1;
                    consume     = hold_full_q;
                    if (hold_full_q) begin
                        sym_data_d = hold_q;
                    end else begin
                        underrun_d = 1'b1;
                    end
                    if (cnt_q == len_last) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        cnt_d        = '0;
                        state_d      = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (sym_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (stop_req_q) begin
                            state_d    = ST_IDLE;
                            stop_req_d = 1'b0;
                            clear_asm  = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Consume and load are exclusive: loading needs bit_en, which is low while the hold register is full.
    always_comb begin
        shift_d     = shift_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (bit_accept) begin
            shift_d = shift_in;
            if ((bcnt_q + 3'd1) >= bits_needed) begin
                hold_d      = mod_q ? shift_in : {2'b00, shift_in[1:0]};
                hold_full_d = 1'b1;
                bcnt_d      = 3'd0;
            end else begin
                bcnt_d = bcnt_q + 3'd1;
            end
        end
        if (clear_asm) begin
            shift_d     = 4'h0;
            bcnt_d      = 3'd0;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stop_req_q   <= 1'b0;
            mod_q        <= 1'b0;
            baud_q       <= 2'd0;
            len_q        <= 9'd0;
            sym_data_q   <= 4'h0;
            sym_valid_q  <= 1'b0;
            preamble_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
            underrun_q   <= 1'b0;
            shift_q      <= 4'h0;
            bcnt_q       <= 3'd0;
            hold_q       <= 4'h0;
            hold_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stop_req_q   <= stop_req_d;
            mod_q        <= mod_d;
            baud_q       <= baud_d;
            len_q        <= len_d;
            sym_data_q   <= sym_data_d;
            sym_valid_q  <= sym_valid_d;
            preamble_q   <= preamble_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            underrun_q   <= underrun_d;
            shift_q      <= shift_d;
            bcnt_q       <= bcnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
        end
    end

    assign mod_type   = mod_q;
    assign baud_rate  = baud_q;
    assign sym_data   = sym_data_q;
    assign sym_valid  = sym_valid_q;
    assign preamble   = preamble_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Bench for qam_frame_ctrl: slot-indexed frame model with a bit-queue assembler feeds a scoreboard of expected symbols.
module tb_qam_frame_ctrl;

    localparam int PRE = 8;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_mod_type = 1'b0;
    logic [1:0]  cfg_baud_rate = 2'd0;
    logic [7:0]  cfg_frame_len = 8'd4;
    logic        bit_tick = 1'b0;
    logic        bit_in = 1'b0;
    logic        sym_tick = 1'b0;
    logic        bit_en;
    logic        mod_type;
    logic [1:0]  baud_rate;
    logic [3:0]  sym_data;
    logic        sym_valid;
    logic        preamble;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        underrun;

    qam_frame_ctrl #(.PREAMBLE_LEN(PRE), .GAP_LEN(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_mod_type(cfg_mod_type), .cfg_baud_rate(cfg_baud_rate), .cfg_frame_len(cfg_frame_len),
        .bit_tick(bit_tick), .bit_in(bit_in), .sym_tick(sym_tick),
        .bit_en(bit_en), .mod_type(mod_type), .baud_rate(baud_rate),
        .sym_data(sym_data), .sym_valid(sym_valid), .preamble(preamble), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  data;
        logic        pre;
        logic        done;
        logic [15:0] cnt;
        logic        und;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // stimulus knobs
    logic rst_v = 1'b0;
    logic pend_start = 1'b0;
    logic pend_stop = 1'b0;
    int   sym_per = 4;
    int   bit_per = 1;
    int   bit_ph = 0;
    logic rnd = 1'b0;
    logic rnd_cfg = 1'b0;
    int   p_start = 0;
    int   p_stop = 0;
    int   cyc = 0;
    logic [6:0] lfsr = 7'h5A;

    // reference model: frame position as a slot index, assembler as a bit queue
    logic        m_active = 1'b0;
    logic        m_load = 1'b0;
    logic        m_stopreq = 1'b0;
    logic        m_mod = 1'b0;
    logic [1:0]  m_baud = 2'd0;
    int          m_len = 0;
    int          m_slot = 0;
    logic [15:0] m_frames = 16'd0;
    logic        m_underrun = 1'b0;
    logic        m_hold_full = 1'b0;
    logic [3:0]  m_hold = 4'h0;
    logic        m_was_rst = 1'b1;
    bit          bq[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic model_en();
        return m_active && !m_load && (m_slot < PRE + m_len) && !m_hold_full;
    endfunction

    task automatic cycle();
        logic st, sp, stk, btk, en, old_stop, bi;
        logic [21:0] e_vec, a_vec;
        exp_t item;
        int need;
        logic [3:0] v;
        @(negedge clk);
        e_vec = {m_active, model_en(), m_mod, m_baud, m_underrun, m_frames};
        a_vec = {busy, bit_en, mod_type, baud_rate, underrun, frame_cnt};
        chk("state_outs", 64'(a_vec), 64'(e_vec));
        if (m_was_rst) chk("reset_sym", 64'({sym_data, sym_valid, preamble, frame_done}), 64'd0);

        st = pend_start || (p_start != 0 && $urandom_range(p_start - 1) == 0);
        sp = pend_stop  || (p_stop  != 0 && $urandom_range(p_stop - 1) == 0);
        pend_start = 1'b0;
        pend_stop  = 1'b0;
        if (rnd) begin
            stk = ($urandom_range(sym_per - 1) == 0);
            btk = ($urandom_range(bit_per - 1) == 0);
        end else begin
            stk = (cyc % sym_per == 0);
            btk = (cyc % bit_per == bit_ph);
        end
        if (rnd_cfg) begin
            if ($urandom_range(15) == 0) cfg_mod_type = ~cfg_mod_type;
            if ($urandom_range(15) == 0) cfg_baud_rate = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) cfg_frame_len = 8'($urandom_range(12, 1));
        end
        bi = lfsr[6];
        rst_n = rst_v; start = st; stop = sp; sym_tick = stk; bit_tick = btk; bit_in = bi;

        if (!rst_v) begin
            m_active = 0; m_load = 0; m_stopreq = 0; m_mod = 0; m_baud = 0; m_len = 0;
            m_slot = 0; m_frames = 0; m_underrun = 0; m_hold_full = 0; m_hold = 0;
            bq.delete();
            m_was_rst = 1;
        end else begin
            m_was_rst = 0;
            en = model_en();
            old_stop = m_stopreq;
            if (!m_active) begin
                if (st) begin
                    m_active = 1; m_load = 1; m_underrun = 0; m_stopreq = sp;
                end
            end else if (m_load) begin
                m_stopreq = m_stopreq | sp;
                m_mod = cfg_mod_type;
                m_baud = cfg_baud_rate;
                m_len = (cfg_frame_len == 8'd0) ? 256 : int'(cfg_frame_len);
                m_slot = 0;
                m_load = 0;
            end else begin
                m_stopreq = m_stopreq | sp;
                if (stk) begin
                    if (m_slot < PRE) begin
                        item.data = (m_slot % 2 == 0) ? (m_mod ? 4'hF : 4'h3) : 4'h0;
                        item.pre = 1; item.done = 0; item.cnt = m_frames; item.und = m_underrun;
                        exp_q.push_back(item);
                        m_slot++;
                    end else if (m_slot < PRE + m_len) begin
                        item.data = m_hold_full ? m_hold : 4'h0;
                        if (!m_hold_full) m_underrun = 1;
                        m_hold_full = 0;
                        item.done = (m_slot == PRE + m_len - 1);
                        if (item.done) m_frames = m_frames + 16'd1;
                        item.pre = 0; item.cnt = m_frames; item.und = m_underrun;
                        exp_q.push_back(item);
                        m_slot++;
                    end else if (m_slot < PRE + m_len + GAP - 1) begin
                        m_slot++;
                    end else if (old_stop) begin
                        m_active = 0; m_stopreq = 0; m_hold_full = 0;
                        bq.delete();
                    end else begin
                        m_load = 1;
                    end
                end
            end
            if (btk && en) begin
                bq.push_back(bi);
                lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                need = m_mod ? 4 : 2;
                if (bq.size() >= need) begin
                    v = 4'h0;
                    for (int i = bq.size() - need; i < bq.size(); i++) v = {v[2:0], bq[i]};
                    m_hold = v;
                    m_hold_full = 1;
                    bq.delete();
                end
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(int limit, string name);
        int k = 0;
        cycle();
        cycle();
        while (m_active && k < limit) begin
            cycle();
            k++;
        end
        cycle();
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sym_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sym_unexpected", 64'(sym_data), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("sym_out", 64'({sym_data, preamble, frame_done, frame_cnt, underrun}), 64'(e));
                end
            end else begin
                chk("stray_flags", 64'({frame_done, preamble}), 64'd0);
            end
        end
    end

    initial begin
        int k;
        logic [15:0] f0;
        repeat (3) cycle();
        rst_v = 1'b1;
        cycle();

        // 16QAM, 4-symbol frame, start+stop together: exactly one frame
        cfg_mod_type = 1; cfg_baud_rate = 2'd2; cfg_frame_len = 8'd4;
        sym_per = 8; bit_per = 2; bit_ph = 1;
        pend_start = 1; pend_stop = 1;
        run_until_idle(1000, "A");
        chk("A_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("A_underrun", 64'(underrun), 64'd0);

        // QPSK, 256-symbol frames, back to back
        cfg_mod_type = 0; cfg_baud_rate = 2'd1; cfg_frame_len = 8'd0;
        sym_per = 4; bit_per = 1; bit_ph = 0;
        f0 = m_frames;
        pend_start = 1;
        k = 0;
        while (m_frames != f0 + 16'd2 && k < 5000) begin
            cycle();
            k++;
        end
        cycle();
        chk("B_frame_cnt", 64'(frame_cnt), 64'(f0 + 16'd2));
        chk("B_busy", 64'(busy), 64'd1);
        repeat (100) cycle();
        pend_stop = 1;
        run_until_idle(2000, "B");

        // cfg churn mid-frame, random ticks, stop mid-frame
        cfg_frame_len = 8'd7;
        rnd = 1; rnd_cfg = 1; sym_per = 6; bit_per = 2;
        pend_start = 1;
        repeat (600) cycle();
        pend_stop = 1;
        run_until_idle(1500, "C");
        rnd = 0; rnd_cfg = 0;

        // bit rate too slow for 16QAM: underrun, cleared by the next start
        cfg_mod_type = 1; cfg_frame_len = 8'd6;
        sym_per = 4; bit_per = 8; bit_ph = 3;
        pend_start = 1; pend_stop = 1;
        run_until_idle(1000, "D");
        chk("D_underrun_set", 64'(underrun), 64'd1);
        bit_per = 1; bit_ph = 0;
        pend_start = 1;
        cycle();
        cycle();
        chk("D_underrun_clr", 64'(underrun), 64'd0);
        pend_stop = 1;
        run_until_idle(1000, "D2");

        // reset in the middle of a payload
        cfg_frame_len = 8'd20;
        pend_start = 1;
        k = 0;
        while (!(m_active && !m_load && m_slot >= PRE + 2) && k < 2000) begin
            cycle();
            k++;
        end
        rst_v = 0;
        cycle();
        rst_v = 1;
        cycle();
        chk("E_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("E_busy", 64'(busy), 64'd0);
        chk("E_bit_en", 64'(bit_en), 64'd0);

        // random mix: stray starts/stops while busy, cfg churn, random rates
        rnd = 1; rnd_cfg = 1; sym_per = 5; bit_per = 3;
        p_start = 40; p_stop = 300;
        repeat (3000) cycle();
        p_start = 0; p_stop = 0;
        pend_stop = 1;
        run_until_idle(2000, "F");
        rnd = 0; rnd_cfg = 0;

        repeat (4) cycle();
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qam_frame_ctrl.md
QAM_FRAME_CTRL -- requirements
Module: qam_frame_ctrl

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8, number of preamble symbols per frame.
REQ-002 SHALL have parameter GAP_LEN, default 4, number of idle symbol slots between frames.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin framing.
REQ-006 SHALL have port stop  input  1  one-cycle request to end after the current frame.
REQ-007 SHALL have port cfg_mod_type  input  1  0 = QPSK (2 bits/symbol), 1 = 16QAM (4 bits/symbol).
REQ-008 SHALL have port cfg_baud_rate  input  2  baud-rate select forwarded to the clock generator.
REQ-009 SHALL have port cfg_frame_len  input  8  payload symbols per frame; 0 means 256.
REQ-010 SHALL have port bit_tick  input  1  one-cycle bit-rate strobe.
REQ-011 SHALL have port bit_in  input  1  serial bit from the m-sequence source.
REQ-012 SHALL have port sym_tick  input  1  one-cycle symbol-rate strobe.
REQ-013 SHALL have port bit_en  output  1  gates the bit source; the source advances only on bit_tick && bit_en.
REQ-014 SHALL have port mod_type  output  1  latched modulation type.
REQ-015 SHALL have port baud_rate  output  2  latched baud-rate select.
REQ-016 SHALL have port sym_data  output  4  symbol to the mapper; QPSK uses [1:0], with [3:2] = 0.
REQ-017 SHALL have port sym_valid  output  1  one-cycle pulse qualifying sym_data.
REQ-018 SHALL have port preamble  output  1  high with sym_valid when the symbol is preamble.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port frame_done  output  1  one-cycle pulse when the last payload symbol is emitted.
REQ-021 SHALL have port frame_cnt  output  16  count of completed frames; wraps 0xFFFF to 0.
REQ-022 SHALL have port underrun  output  1  sticky flag: a payload slot occurred with no assembled symbol.

Function
REQ-023 SHALL implement the states IDLE, LOAD, PREAMBLE, PAYLOAD and GAP.
REQ-024 IDLE: on start, SHALL clear underrun and move to LOAD; start in any other state SHALL be ignored.
REQ-025 LOAD: for one cycle, SHALL latch cfg_* into mod_type, baud_rate and the frame length, then move to PREAMBLE; cfg_* changes take effect only here.
REQ-026 PREAMBLE: each sym_tick SHALL emit one preamble symbol.
- Preamble symbols alternate starting high: 16QAM 4'hF, 4'h0, ...; QPSK 4'h3, 4'h0, ...
- After PREAMBLE_LEN symbols, SHALL move to PAYLOAD.
REQ-027 PAYLOAD: each sym_tick SHALL emit one symbol and consume the hold register.
- If the hold register is empty, SHALL emit 4'h0 and set underrun.
- On the frame-length-th symbol, SHALL pulse frame_done, increment frame_cnt and move to GAP.
REQ-028 GAP: SHALL count GAP_LEN sym_ticks with sym_valid low, then go to IDLE if stop_req is set, else go to LOAD.
REQ-029 stop SHALL set a sticky stop_req in any non-IDLE state; stop_req SHALL be cleared on entry to IDLE.
- start and stop in the same IDLE cycle: exactly one frame is sent.
REQ-030 Bit assembler:
- bit_en = (state is PREAMBLE or PAYLOAD) && !hold_full, combinational.
- Each accepted bit SHALL shift into the shift register MSB-first.
- After 2 (QPSK) or 4 (16QAM) bits, SHALL load the hold register, set hold_full and reset the bit count.
REQ-031 Because bit_en is low while hold_full, a bit_tick in the same cycle as a consuming sym_tick SHALL be neither accepted nor advance the source.
REQ-032 sym_data, sym_valid and preamble SHALL be registered, with a latency of exactly 1 clk after sym_tick.
REQ-033 On entering IDLE, the shift register, bit count and hold_full SHALL be cleared; partial bits are discarded.

Reset
REQ-034 When rst_n is low at a clk edge, the block SHALL enter IDLE, clear stop_req, shift register, counters and hold_full, and drive every output to 0 (bit_en 0, sym_data 4'h0, frame_cnt 0, underrun 0).
REQ-035 Reset asserted mid-frame SHALL abort immediately, with no frame_done pulse and no frame_cnt increment.

Verification
REQ-036 16QAM, frame_len=4, start+stop same cycle, bit_tick 4x sym_tick:
- response: 8 preamble symbols F,0,F,0,...; then 4 payload symbols matching the m-sequence nibbles MSB-first.
- frame_done once, frame_cnt=1, then IDLE with busy low.
REQ-037 QPSK, frame_len=0, continuous with no stop:
- response: 256 payload symbols per frame, sym_data[3:2]=0 throughout, 4 idle slots between frames, frame_cnt increments each frame.
REQ-038 cfg_mod_type toggled mid-frame:
- response: mod_type unchanged until the next LOAD; stop mid-frame completes that frame then IDLE.
REQ-039 bit_tick rate halved (16QAM):
- response: underrun=1 and a 4'h0 symbol emitted; underrun is cleared by the next start from IDLE.
REQ-040 rst_n low during PAYLOAD:
- response: next clk edge gives all outputs 0 and state IDLE; frame_cnt is unchanged from its pre-frame value only if reset was not applied, otherwise 0.
